// File: rtl/mac_accum_16_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the MAC engine
// and the downstream sigmoid bank that consumes its packed sum bus.
package dbn_pkg;

  localparam int LANES  = 16;
  localparam int DATA_W = 16;
  localparam int SUM_W  = 32;
  localparam int CNT_W  = 10;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } mac_state_e;

  typedef struct packed {
    logic             ovf;
    logic [SUM_W-1:0] sum;
  } sat_res_t;

  // One guard bit is enough: the sign of the wide result disagrees with the
  // top bit of the narrow result exactly when the signed sum left the range.
  function automatic sat_res_t sat_add(input logic [SUM_W-1:0]  acc,
                                       input logic [PROD_W-1:0] prod);
    logic [SUM_W:0] wide;
    sat_res_t       res;
    wide    = {acc[SUM_W-1], acc} + {{(SUM_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    res.ovf = wide[SUM_W] ^ wide[SUM_W-1];
    if (res.ovf) begin
      res.sum = wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    end else begin
      res.sum = wide[SUM_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_accum_16_if.sv
// Beat input and packed-sum output bus of the MAC engine; the engine uses the
// slave view, the upstream/downstream environment the master view.
interface mac_accum_16_if;
  import dbn_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic [DATA_W-1:0]       act_in;
  logic [LANES*DATA_W-1:0] weight_in;
  logic [LANES*SUM_W-1:0]  bias_in;
  logic [LANES*SUM_W-1:0]  sum_output;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    ovf;

  modport slave (
    input  in_valid, in_last, act_in, weight_in, bias_in, out_ready,
    output in_ready, sum_output, out_valid, beat_cnt, ovf
  );

  modport master (
    output in_valid, in_last, act_in, weight_in, bias_in, out_ready,
    input  in_ready, sum_output, out_valid, beat_cnt, ovf
  );

endinterface

// File: rtl/mac_accum_16_lane.sv
// One MAC lane: signed product, bias-or-accumulator select on the first beat,
// saturating add and the accumulator register.
module mac_lane
  import dbn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_i,
  input  logic              first_i,
  input  logic [DATA_W-1:0] act_i,
  input  logic [DATA_W-1:0] weight_i,
  input  logic [SUM_W-1:0]  bias_i,
  output logic [SUM_W-1:0]  acc_o,
  output logic              sat_o
);

  logic signed [DATA_W-1:0] actS;
  logic signed [DATA_W-1:0] weightS;
  logic signed [PROD_W-1:0] prod;
  logic [SUM_W-1:0]         base;
  logic [SUM_W-1:0]         acc_q;
  logic [SUM_W-1:0]         acc_d;
  sat_res_t                 res;

  assign actS    = act_i;
  assign weightS = weight_i;
  assign prod    = PROD_W'(actS) * PROD_W'(weightS);
  assign base    = first_i ? bias_i : acc_q;
  assign res     = sat_add(base, prod);
  assign acc_d   = beat_i ? res.sum : acc_q;
  assign sat_o   = beat_i & res.ovf;
  assign acc_o   = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mac_accum_16.sv
// 16-lane signed multiply-accumulate engine: accumulates beats into saturating
// per-lane sums and hands the finished vector to the sigmoid bank.
module mac_accum_16
  import dbn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mac_accum_16_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mac_state_e       state_q;
  mac_state_e       state_d;
  logic [CNT_W-1:0] beatCnt_q;
  logic [CNT_W-1:0] beatCnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             beat;
  logic             first;
  logic             anySat;
  logic             cntSat;
  logic [SUM_W-1:0] laneAcc [LANES];
  logic [LANES-1:0] laneSat;

  assign beat   = bus.in_valid && (state_q != HOLD);
  assign first  = (state_q == IDLE);
  assign anySat = |laneSat;
  assign cntSat = (beatCnt_q >= CNT_MAX - 1'b1);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .beat_i   (beat),
      .first_i  (first),
      .act_i    (bus.act_in),
      .weight_i (bus.weight_in[i*DATA_W +: DATA_W]),
      .bias_i   (bus.bias_in[i*SUM_W +: SUM_W]),
      .acc_o    (laneAcc[i]),
      .sat_o    (laneSat[i])
    );
  end

  // The accumulators only move on accepted beats, so they double as the
  // output register and stay stable for the whole HOLD state.
  always_comb begin
    bus.sum_output = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.sum_output[i*SUM_W +: SUM_W] = laneAcc[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    beatCnt_d = beatCnt_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          beatCnt_d = CNT_W'(1);
          ovf_d     = anySat;
          state_d   = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          beatCnt_d = cntSat ? CNT_MAX : beatCnt_q + 1'b1;
          ovf_d     = ovf_q | anySat | cntSat;
          if (bus.in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beatCnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.beat_cnt  = beatCnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_accum_16.sv
// Bench for mac_accum_16: single-beat table vectors, hand-written multi-beat
// sequences, and a queue-based scoreboard fed by a behavioural model.
module tb_mac_accum_16;
  import dbn_pkg::*;

  localparam int BUS_W = LANES * SUM_W;
  localparam int WB_W  = LANES * DATA_W;
  localparam longint SAT_MAX = 64'sd2147483647;
  localparam longint SAT_MIN = -64'sd2147483648;

  typedef struct {
    logic [BUS_W-1:0] sums;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [15:0] act;
    logic [15:0] w;
    logic [31:0] bias;
    logic [31:0] expSum;
    logic        expOvf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  mac_accum_16_if bus();

  mac_accum_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     checkCount = 0;
  int     passCount  = 0;
  exp_t   expQ[$];
  exp_t   lastExp;
  longint refAcc [LANES];
  logic   refOvf = 1'b0;
  int     refCnt = 0;
  bit     refFirst = 1'b1;
  int     readyMode = 2;
  int     outXfers = 0;
  bit     prevValid = 1'b0;

  task automatic checkOutput(input string name, input logic [BUS_W-1:0] actual,
                             input logic [BUS_W-1:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
  endtask

  task automatic timeoutFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: got no DUT response, expected one within the cycle bound", name);
  endtask

  // Behavioural reference: 64-bit arithmetic clamped to the signed 32-bit range.
  task automatic modelBeat(input logic [15:0] act, input logic [WB_W-1:0] w,
                           input logic [BUS_W-1:0] bias, input bit last);
    exp_t e;
    if (refFirst) begin
      refOvf = 1'b0;
      refCnt = 0;
    end
    for (int i = 0; i < LANES; i++) begin
      longint prod;
      longint s;
      prod = longint'($signed(act)) * longint'($signed(w[i*16 +: 16]));
      s    = (refFirst ? longint'($signed(bias[i*32 +: 32])) : refAcc[i]) + prod;
      if (s > SAT_MAX) begin
        s = SAT_MAX;
        refOvf = 1'b1;
      end else if (s < SAT_MIN) begin
        s = SAT_MIN;
        refOvf = 1'b1;
      end
      refAcc[i] = s;
    end
    if (refCnt < 1023) refCnt++;
    if (refCnt == 1023) refOvf = 1'b1;
    refFirst = 1'b0;
    if (last) begin
      for (int i = 0; i < LANES; i++) e.sums[i*32 +: 32] = refAcc[i][31:0];
      e.cnt = refCnt[CNT_W-1:0];
      e.ovf = refOvf;
      expQ.push_back(e);
      refFirst = 1'b1;
    end
  endtask

  // Called in the drive phase (just after a rising edge); returns in the same phase.
  task automatic applyStimulus(input logic [15:0] act, input logic [WB_W-1:0] w,
                               input logic [BUS_W-1:0] bias, input bit last);
    int waited = 0;
    bit done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.act_in    = act;
    bus.weight_in = w;
    bus.bias_in   = bias;
    bus.in_last   = last;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        done = 1'b1;
        modelBeat(act, w, bias, last);
      end else if (++waited > 100) begin
        timeoutFail("beat accept");
        done = 1'b1;
      end
      @(posedge clk);
      #2;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitValid(input bit level, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== level && n < 200);
    if (bus.out_valid !== level) timeoutFail(name);
  endtask

  task automatic toDrivePhase();
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) toDrivePhase();
  endtask

  // Scoreboard: pop one expected vector on each rising out_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prevValid = 1'b0;
      end else begin
        if (bus.out_valid === 1'b1 && !prevValid) begin
          if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL sb pending: got out_valid=1, expected no output (queue empty)");
          end else begin
            lastExp = expQ.pop_front();
            checkOutput("sb sums", bus.sum_output, lastExp.sums);
            checkOutput("sb beat_cnt", BUS_W'(bus.beat_cnt), BUS_W'(lastExp.cnt));
            checkOutput("sb ovf", BUS_W'(bus.ovf), BUS_W'(lastExp.ovf));
          end
        end else if (bus.out_valid === 1'b1) begin
          checkOutput("sb hold stable", bus.sum_output, lastExp.sums);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) outXfers++;
        prevValid = (bus.out_valid === 1'b1);
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global timeout: got no finish, expected finish before 400000");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    vec_t             vecs [7];
    logic [WB_W-1:0]  w;
    logic [BUS_W-1:0] b;
    int               x0;

    vecs[0] = '{16'd3,      16'hFFFB, 32'd100,      32'd85,         1'b0};
    vecs[1] = '{16'h7FFF,   16'h7FFF, 32'h7FFF0000, 32'h7FFFFFFF,   1'b1};
    vecs[2] = '{16'h8000,   16'h8000, 32'd0,        32'h40000000,   1'b0};
    vecs[3] = '{16'h8000,   16'h7FFF, 32'h80000000, 32'h80000000,   1'b1};
    vecs[4] = '{16'hFFFF,   16'h0001, 32'd0,        32'hFFFFFFFF,   1'b0};
    vecs[5] = '{16'h0000,   16'd1234, 32'hFFFFFFF9, 32'hFFFFFFF9,   1'b0};
    vecs[6] = '{16'd100,    16'hFF9C, 32'd10000,    32'd0,          1'b0};

    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.act_in    = '0;
    bus.weight_in = '0;
    bus.bias_in   = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", BUS_W'(bus.out_valid), BUS_W'(1'b0));
    checkOutput("reset in_ready", BUS_W'(bus.in_ready), BUS_W'(1'b1));
    checkOutput("reset beat_cnt", BUS_W'(bus.beat_cnt), '0);
    checkOutput("reset ovf", BUS_W'(bus.ovf), '0);
    checkOutput("reset sums", bus.sum_output, '0);
    toDrivePhase();
    rst_n = 1'b1;
    readyMode = 0;
    idleCycles(2);

    $display("[TB] single-beat table vectors");
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k].act, {LANES{vecs[k].w}}, {LANES{vecs[k].bias}}, 1'b1);
      waitValid(1'b1, "table valid");
      checkOutput("table lane0", BUS_W'(bus.sum_output[31:0]), BUS_W'(vecs[k].expSum));
      checkOutput("table lane15", BUS_W'(bus.sum_output[BUS_W-1 -: 32]), BUS_W'(vecs[k].expSum));
      checkOutput("table ovf", BUS_W'(bus.ovf), BUS_W'(vecs[k].expOvf));
      checkOutput("table beat_cnt", BUS_W'(bus.beat_cnt), BUS_W'(10'd1));
      waitValid(1'b0, "table release");
      toDrivePhase();
    end

    $display("[TB] four beats with output backpressure");
    readyMode = 2;
    idleCycles(2);
    for (int k = 1; k <= 4; k++) applyStimulus(16'(k), {LANES{16'd2}}, '0, k == 4);
    waitValid(1'b1, "hold valid");
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("hold in_ready", BUS_W'(bus.in_ready), BUS_W'(1'b0));
      checkOutput("hold out_valid", BUS_W'(bus.out_valid), BUS_W'(1'b1));
      checkOutput("hold sums", bus.sum_output, {LANES{32'd20}});
    end
    x0 = outXfers;
    readyMode = 0;
    waitValid(1'b0, "hold release");
    checkOutput("hold xfer count", BUS_W'(outXfers - x0), BUS_W'(1));
    checkOutput("bubble in_ready", BUS_W'(bus.in_ready), BUS_W'(1'b1));
    toDrivePhase();

    $display("[TB] two-beat saturation");
    applyStimulus(16'h7FFF, {LANES{16'h7FFF}}, {LANES{32'h7FFF0000}}, 1'b0);
    applyStimulus(16'h7FFF, {LANES{16'h7FFF}}, {LANES{32'h7FFF0000}}, 1'b1);
    waitValid(1'b1, "sat+ valid");
    checkOutput("sat+ lane3", BUS_W'(bus.sum_output[3*32 +: 32]), BUS_W'(32'h7FFFFFFF));
    checkOutput("sat+ ovf", BUS_W'(bus.ovf), BUS_W'(1'b1));
    waitValid(1'b0, "sat+ release");
    toDrivePhase();
    applyStimulus(16'h7FFF, {LANES{16'h8000}}, {LANES{32'h80010000}}, 1'b0);
    applyStimulus(16'h7FFF, {LANES{16'h8000}}, {LANES{32'h80010000}}, 1'b1);
    waitValid(1'b1, "sat- valid");
    checkOutput("sat- lane9", BUS_W'(bus.sum_output[9*32 +: 32]), BUS_W'(32'h80000000));
    checkOutput("sat- ovf", BUS_W'(bus.ovf), BUS_W'(1'b1));
    waitValid(1'b0, "sat- release");
    toDrivePhase();

    $display("[TB] lane independence with random out_ready");
    for (int i = 0; i < LANES; i++) w[i*16 +: 16] = 16'(i);
    readyMode = 1;
    x0 = outXfers;
    applyStimulus(16'd10, w, '0, 1'b1);
    waitValid(1'b1, "lanes valid");
    for (int i = 0; i < LANES; i++) begin
      checkOutput($sformatf("lane%0d slice", i), BUS_W'(bus.sum_output[i*32 +: 32]), BUS_W'(32'(10 * i)));
    end
    waitValid(1'b0, "lanes release");
    repeat (3) @(negedge clk);
    checkOutput("lanes xfer count", BUS_W'(outXfers - x0), BUS_W'(1));
    readyMode = 0;
    toDrivePhase();

    $display("[TB] seven beats with input gaps");
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < LANES; i++) w[i*16 +: 16] = 16'($urandom);
      for (int i = 0; i < LANES; i++) b[i*32 +: 32] = $urandom;
      applyStimulus(16'($urandom), w, b, k == 6);
      if (k < 6) idleCycles($urandom_range(0, 3));
    end
    waitValid(1'b1, "gaps valid");
    checkOutput("gaps beat_cnt", BUS_W'(bus.beat_cnt), BUS_W'(10'd7));
    waitValid(1'b0, "gaps release");
    toDrivePhase();

    $display("[TB] async reset mid-vector");
    for (int k = 0; k < 3; k++) applyStimulus(16'd1000, {LANES{16'd1000}}, {LANES{32'd77}}, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst out_valid", BUS_W'(bus.out_valid), BUS_W'(1'b0));
    checkOutput("rst sums", bus.sum_output, '0);
    checkOutput("rst beat_cnt", BUS_W'(bus.beat_cnt), '0);
    refFirst = 1'b1;
    toDrivePhase();
    rst_n = 1'b1;
    toDrivePhase();
    applyStimulus(16'd2, {LANES{16'd3}}, {LANES{32'd5000}}, 1'b1);
    waitValid(1'b1, "post-rst valid");
    checkOutput("post-rst lane0", BUS_W'(bus.sum_output[31:0]), BUS_W'(32'd5006));
    waitValid(1'b0, "post-rst release");
    toDrivePhase();

    $display("[TB] async reset during hold");
    readyMode = 2;
    idleCycles(2);
    applyStimulus(16'd7, {LANES{16'd7}}, '0, 1'b1);
    waitValid(1'b1, "hold-rst valid");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("hold-rst out_valid", BUS_W'(bus.out_valid), BUS_W'(1'b0));
    toDrivePhase();
    rst_n = 1'b1;
    readyMode = 0;
    idleCycles(3);

    checkOutput("sb queue drained", BUS_W'(expQ.size()), '0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mac_accum_16.md
Name: mac_accum_16

Overview:
- 16-lane signed multiply-accumulate engine that produces the packed 512-bit sum bus consumed by the 16-lane sigmoid stage. This is the writer side of that bus.
- Each accepted beat carries:
  - one broadcast 16-bit activation;
  - 16 per-lane 16-bit weights.
- Each lane accumulates activation×weight into a 32-bit saturating accumulator, with an optional bias preload on the first beat.
- On the beat flagged last, the 16 sums are presented with a valid/ready handshake to the downstream sigmoid bank.

Parameters:
- LANES, 16, number of parallel neurons; sum bus width is LANES*SUM_W.
- DATA_W, 16, activation and weight width (signed two's complement).
- SUM_W, 32, accumulator and output width per lane (signed).
- CNT_W, 10, beat counter width (max 1023 beats per vector).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_last  in  1  final beat of current vector.
- act_in  in  DATA_W  broadcast activation, signed.
- weight_in  in  LANES*DATA_W  lane i weight at [i*16+15:i*16], signed.
- bias_in  in  LANES*SUM_W  lane i bias at [i*32+31:i*32]; sampled only on the first beat of a vector.
- sum_output  out  LANES*SUM_W  lane i sum at [i*32+31:i*32]; same packing the sigmoid bank expects.
- out_valid  out  1  sum_output holds a completed vector.
- out_ready  in  1  downstream accepts.
- beat_cnt  out  CNT_W  beats accepted in the current or last vector.
- ovf  out  1  sticky: a lane saturated in the current or last vector.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All accumulators, sum_output, beat_cnt and ovf are 0.
  - out_valid=0; in_ready=1 after release.
- Handshake: a beat transfers when in_valid&in_ready; an output transfers when out_valid&out_ready.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1.
    - On a beat: acc[i] = sat(bias[i] + act*w[i]); beat_cnt=1; ovf = that beat's saturation.
    - If in_last: go to HOLD; otherwise go to ACCUM.
  - ACCUM: in_ready=1.
    - On a beat: acc[i] = sat(acc[i] + act*w[i]); beat_cnt += 1; ovf |= saturation.
    - If in_last: go to HOLD.
    - No beat: hold everything.
  - HOLD: in_ready=0; out_valid=1; sum_output = acc.
    - On out_ready: go to IDLE, out_valid=0 next cycle.
    - beat_cnt and ovf hold until the next first beat.
- Latency: sum_output/out_valid are registered and visible the cycle after the last beat is accepted. One bubble is inserted between output acceptance and the next first beat (in_ready rises in IDLE).
- Arithmetic:
  - Product is the full signed DATA_W×DATA_W → 2*DATA_W result, sign-extended to SUM_W+1.
  - The add is done at SUM_W+1 bits, then saturated to [−2^31, 2^31−1]; the saturate event sets ovf.
  - A product of −32768×−32768 = 2^30 is representable; no product overflow.
- beat_cnt saturates at 2^CNT_W−1 and does not wrap. Reaching saturation also sets ovf.
- Single-beat vector (first beat with in_last=1) is legal; result is bias+product.
- out_ready high in IDLE/ACCUM is ignored.
- in_valid in HOLD is not accepted; the upstream must hold its beat.
- Async reset mid-vector discards the partial sums immediately. out_valid drops asynchronously.
- sum_output is stable throughout HOLD. It is not required to change outside HOLD but keeps the last value.

Decomposition:
- Shared package dbn_pkg:
  - constants LANES=16, DATA_W=16, SUM_W=32;
  - FSM state enum {IDLE, ACCUM, HOLD};
  - a function sat_add(acc, prod) returning the saturated sum plus an overflow bit.
- Sub-module mac_lane:
  - one lane with inputs: signed multiply, first-beat select (bias vs acc), saturating add, accumulator register, overflow flag.
  - generate-instantiated LANES times.
- The FSM and beat counter live in mac_accum_16.

Test Plan:
- Single beat: bias lane0=100, act=3, w0=−5, in_last=1 → sum lane0=85 one cycle after accept, out_valid=1, beat_cnt=1, ovf=0.
- Four beats: act=1,2,3,4, all w=2, bias=0 → every lane=20. in_ready=0 while out_valid=1 and out_ready=0 for 5 cycles; sum stable until out_ready, then out_valid=0.
- Saturation: bias=0x7FFF0000, act=32767, w=32767 over 2 beats → lane=0x7FFFFFFF, ovf=1. Negative case with w=−32768 → 0x80000000, ovf=1.
- Lane independence: w_i=i, act=10, one beat → lane i = 10*i for i=0..15 at the correct bit slices; out_ready is toggled randomly but the sum is accepted exactly once.
- Backpressure and gaps: in_valid deasserted randomly mid-vector over 7 beats → sums equal to a reference model; beat_cnt=7.
- Async reset asserted mid-ACCUM after 3 beats → out_valid=0, sum=0, beat_cnt=0 immediately; the next vector computes from the new bias with no residue.
